square_meter: RTL and testbench
===============================

# square_meter

- Measures an incoming 8-bit sampled waveform.
- Runs the samples through a hysteresis comparator to recover a binary level.
- Measures period and high time, both in accepted samples, and reports each completed cycle with a one-cycle valid pulse.
- Sits on the analysis side of the function generator: it checks the generator's square output and any square-like stream fed to it.

## Interface
Parameters:
- HI_TH, 8'd192: rising threshold; a sample >= HI_TH while level is low sets level high.
- LO_TH, 8'd64: falling threshold; a sample <= LO_TH while level is high sets level low. LO_TH < HI_TH is required.
- CNT_W, 16: width of the period and high-time counters and outputs.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_en  in  1  qualifies `sample` for one clock; it may be held high continuously.
- sample  in  8  unsigned sample value.
- level  out  1  comparator level after hysteresis.
- locked  out  1  high while the FSM is in MEASURE.
- period  out  CNT_W  last measured period, in accepted samples.
- high_time  out  CNT_W  number of accepted samples with level high in the last period.
- meas_valid  out  1  one-clock pulse when period and high_time update.
- timeout  out  1  one-clock pulse when the period counter saturates.

## Operation
- An accepted sample is a clock edge with sample_en=1. No state changes on any other cycle.
- Comparator: rise event = level==0 and sample>=HI_TH. Fall event = level==1 and sample<=LO_TH. level takes its new value on that edge; otherwise it holds. Samples strictly between the thresholds never change level.
- Counters: period_cnt and high_cnt, both CNT_W bits. MAX = 2^CNT_W-1.

FSM:
- SYNC (reset state): on an accepted rise event, period_cnt<=1, high_cnt<=1, go to MEASURE. No outputs other than level change.
- MEASURE, accepted rise event:
  - period<=period_cnt, high_time<=high_cnt, meas_valid<=1.
  - period_cnt<=1, high_cnt<=1.
- MEASURE, accepted sample with no rise event, and period_cnt<MAX:
  - period_cnt<=period_cnt+1.
  - high_cnt<=high_cnt+1 if the post-update level is high. A fall-event sample counts as low.
- MEASURE, accepted sample with no rise event, and period_cnt==MAX:
  - timeout<=1, go to SYNC.
  - period and high_time hold their previous values; meas_valid stays 0.

Ordering and invariants:
- A rise event takes priority over saturation.
- high_cnt <= period_cnt always.
- period >= 2 for any valid measurement, because a fall must occur between two rises.

## Timing
- Reset values: level=0, locked=0, period=0, high_time=0, meas_valid=0, timeout=0. Internally: state=SYNC, both counters=0.
- Reset is asynchronous and takes effect mid-measurement. After release, the first rise event is only a sync edge and produces no meas_valid.
- Outputs are registered. meas_valid and timeout assert on the edge that accepts the triggering sample and clear on the next edge. They never assert together.
- level updates on the same edge as its event. locked rises on the edge that accepts the first rise event and falls on the edge that fires timeout.
- A rise is detectable at most every 2 accepted samples, since the level must return low in between. meas_valid therefore never asserts on two consecutive accepted samples.

## Test plan
- Reset/sync: after rst release, drive 10×0 then a continuous alternating 254-level/1-level square from the generator (128 samples each, sample_en=1) -> locked=1 on the first 254 sample, no meas_valid. Every following rising edge gives meas_valid with period=256, high_time=128.
- Duty and sparse enable: 40 samples at 200, then 60 at 10, repeated, with sample_en high every 3rd clock -> period=100, high_time=40. Idle clocks leave all state unchanged.
- Hysteresis: alternate 150/100 for 50 samples between two valid square cycles -> level never toggles. The measured period includes those 50 samples.
- Threshold boundaries: sample exactly 192 rises and exactly 64 falls; 191 after a low and 65 after a high do not change level.
- Timeout: CNT_W=4, then hold the sample at 0 after lock -> timeout pulses on the accepted sample where period_cnt==15. locked=0 and period is unchanged. The next rise re-syncs without meas_valid.
- Async reset mid-period: assert rst between clock edges during MEASURE -> all outputs clear immediately. After release the first rise gives no meas_valid; the second rise gives a correct measurement.

Source files
------------

// File: rtl/square_meter.sv
// Square-wave meter: a hysteresis comparator recovers a binary level from 8-bit samples,
// then period and high time are counted in accepted samples and reported once per cycle.
module square_meter #(
  parameter logic [7:0] HI_TH = 8'd192,
  parameter logic [7:0] LO_TH = 8'd64,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [7:0]       sample,
  output logic             level,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic {SYNC, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic             level_reg, level_next;
  logic [CNT_W-1:0] period_cnt_reg, period_cnt_next;
  logic [CNT_W-1:0] high_cnt_reg, high_cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic             meas_valid_reg, meas_valid_next;
  logic             timeout_reg, timeout_next;
  logic             rise_evt, fall_evt;

  assign rise_evt = sample_en && !level_reg && (sample >= HI_TH);
  assign fall_evt = sample_en &&  level_reg && (sample <= LO_TH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= SYNC;
      level_reg      <= 1'b0;
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
      period_reg     <= '0;
      high_time_reg  <= '0;
      meas_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      level_reg      <= level_next;
      period_cnt_reg <= period_cnt_next;
      high_cnt_reg   <= high_cnt_next;
      period_reg     <= period_next;
      high_time_reg  <= high_time_next;
      meas_valid_reg <= meas_valid_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    period_cnt_next = period_cnt_reg;
    high_cnt_next   = high_cnt_reg;
    period_next     = period_reg;
    high_time_next  = high_time_reg;
    meas_valid_next = 1'b0;
    timeout_next    = 1'b0;
    level_next      = level_reg;
    if (rise_evt)
      level_next = 1'b1;
    else if (fall_evt)
      level_next = 1'b0;

    if (sample_en) begin
      case (state_reg)
        SYNC: begin
          if (rise_evt) begin
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
            state_next      = MEASURE;
          end
        end
        MEASURE: begin
          // A rise closes the cycle even if the counter has just saturated.
          if (rise_evt) begin
            period_next     = period_cnt_reg;
            high_time_next  = high_cnt_reg;
            meas_valid_next = 1'b1;
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
          end else if (period_cnt_reg != CNT_MAX) begin
            period_cnt_next = period_cnt_reg + CNT_ONE;
            high_cnt_next   = high_cnt_reg + {{(CNT_W-1){1'b0}}, level_next};
          end else begin
            timeout_next = 1'b1;
            state_next   = SYNC;
          end
        end
        default: state_next = SYNC;
      endcase
    end
  end

  assign level      = level_reg;
  assign locked     = (state_reg == MEASURE);
  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign meas_valid = meas_valid_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_square_meter.sv
// Bench for square_meter: directed sample streams with a queue of expected measurements
// checked by an independent monitor, plus a narrow-counter instance for the timeout path.
module tb_square_meter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sample_en, sample_en4;
  logic [7:0]  sample, sample4;
  logic        level, locked, meas_valid, timeout;
  logic [15:0] period, high_time;
  logic        level4, locked4, mv4, to4;
  logic [3:0]  period4, high4;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {logic [15:0] p; logic [15:0] h;} exp_t;
  exp_t q[$];
  exp_t q4[$];

  square_meter #(.HI_TH(8'd192), .LO_TH(8'd64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample),
    .level(level), .locked(locked), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  square_meter #(.HI_TH(8'd192), .LO_TH(8'd64), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sample_en(sample_en4), .sample(sample4),
    .level(level4), .locked(locked4), .period(period4), .high_time(high4),
    .meas_valid(mv4), .timeout(to4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_meas(input int p, input int h);
    q.push_back({p[15:0], h[15:0]});
  endtask

  task automatic expect_meas4(input int p, input int h);
    q4.push_back({p[15:0], h[15:0]});
  endtask

  task automatic acc(input logic [7:0] v);
    sample = v; sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input logic [7:0] v);
    sample = v; sample_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic acc4(input logic [7:0] v);
    sample4 = v; sample_en4 = 1'b1;
    @(posedge clk); #1;
    sample_en4 = 1'b0;
  endtask

  // Monitor: pops an expected measurement for every meas_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (meas_valid === 1'b1) begin
      if (q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_meas: got period=%0d high=%0d, want no pulse", period, high_time);
      end else begin
        e = q.pop_front();
        $display("meas  period=%0d high_time=%0d (want %0d/%0d)", period, high_time, e.p, e.h);
        chk("period", {16'd0, period}, {16'd0, e.p});
        chk("high_time", {16'd0, high_time}, {16'd0, e.h});
      end
    end
    if (mv4 === 1'b1) begin
      if (q4.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_meas4: got period=%0d high=%0d, want no pulse", period4, high4);
      end else begin
        e = q4.pop_front();
        $display("meas4 period=%0d high_time=%0d (want %0d/%0d)", period4, high4, e.p, e.h);
        chk("period4", {28'd0, period4}, {16'd0, e.p});
        chk("high_time4", {28'd0, high4}, {16'd0, e.h});
      end
    end
    if (timeout === 1'b1) begin
      compared++; mismatched++;
      $display("FAIL unexpected_timeout: got 1, want 0");
    end
    if (mv4 === 1'b1 && to4 === 1'b1) begin
      compared++; mismatched++;
      $display("FAIL valid_and_timeout4: got both 1, want exclusive");
    end
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; sample = 8'd0; sample_en4 = 1'b0; sample4 = 8'd0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_locked", locked, 0);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Sync then full-rate 254/1 square, 128 samples each half.
    repeat (10) acc(8'd0);
    chk("locked_before_rise", locked, 0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 128; i++) begin
        if (c > 0 && i == 0) expect_meas(256, 128);
        acc(8'd254);
        if (c == 0 && i == 0) chk("locked_on_first_rise", locked, 1);
      end
      for (int i = 0; i < 128; i++) acc(8'd1);
    end
    expect_meas(256, 128);
    acc(8'd254);

    // Minimum period of 2, then 40/60 duty with enable every third clock.
    acc(8'd0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 100; i++) begin
        logic [7:0] v;
        v = (i < 40) ? 8'd200 : 8'd10;
        if (i == 0) begin
          if (b == 0) expect_meas(2, 1);
          else        expect_meas(100, 40);
        end
        acc(v);
        idle((v >= 8'd128) ? 8'd0 : 8'd255);
        idle((v >= 8'd128) ? 8'd0 : 8'd255);
        if (b == 1 && i == 0)  chk("idle_hold_high", level, 1);
        if (b == 1 && i == 50) chk("idle_hold_low", level, 0);
      end
    end
    expect_meas(100, 40);
    acc(8'd200);

    // Hysteresis: in-band chatter while low must not toggle level.
    for (int i = 1; i < 40; i++) acc(8'd200);
    for (int i = 0; i < 60; i++) acc(8'd10);
    for (int i = 0; i < 50; i++) begin
      acc((i % 2 == 1) ? 8'd100 : 8'd150);
      chk("hyst_level", level, 0);
    end
    expect_meas(150, 40);
    acc(8'd200);

    // Exact threshold boundaries.
    acc(8'd65);  chk("th_65_holds_high", level, 1);
    acc(8'd64);  chk("th_64_falls", level, 0);
    acc(8'd191); chk("th_191_holds_low", level, 0);
    expect_meas(4, 2);
    acc(8'd192); chk("th_192_rises", level, 1);

    // Asynchronous reset between edges during MEASURE.
    acc(8'd200); acc(8'd200);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_locked", locked, 0);
    chk("arst_period", period, 0);
    chk("arst_high_time", high_time, 0);
    chk("arst_meas_valid", meas_valid, 0);
    chk("arst_timeout", timeout, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    acc(8'd10);
    acc(8'd200); chk("arst_relock", locked, 1);
    acc(8'd200); acc(8'd200);
    repeat (5) acc(8'd10);
    expect_meas(8, 3);
    acc(8'd200);

    // Timeout on the 4-bit instance.
    acc4(8'd200); chk("t4_locked", locked4, 1);
    acc4(8'd0);
    expect_meas4(2, 1);
    acc4(8'd200);
    for (int i = 0; i < 14; i++) acc4(8'd0);
    chk("t4_no_timeout_at_14", to4, 0);
    acc4(8'd0);
    chk("t4_timeout", to4, 1);
    chk("t4_unlocked", locked4, 0);
    chk("t4_period_held", period4, 2);
    chk("t4_high_held", high4, 1);
    acc4(8'd0);
    chk("t4_timeout_clears", to4, 0);
    acc4(8'd200); chk("t4_resync", locked4, 1);
    acc4(8'd0);
    expect_meas4(2, 1);
    acc4(8'd200);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size() + q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
